// File: rtl/e_mdu_iter.sv
// rtl/e_mdu_iter.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Execute-stage MDU. A start pulse with a multiply or divide op computes the
// result at once into pending registers, then holds busy for MUL_CYCLES or
// DIV_CYCLES before committing to HI/LO. mthi/mtlo write HI/LO directly in
// one edge without raising busy. Starts seen while busy are dropped.
//
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset
//   start   - qualifies mdu_op for one cycle
//   mdu_op  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//             7 madd, 8 msub (7-8 only with MDU_MADD_EN), others none
//   src_a   - rs operand
//   src_b   - rt operand
//   busy    - operation in flight
//   done    - one-cycle pulse in the cycle after HI/LO commit
//   hi_out  - committed HI register
//   lo_out  - committed LO register
//
// Optional feature macro: MDU_MADD_EN (signed multiply-accumulate ops 7/8).
module e_mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;   // 0 for divide-by-zero: run but keep HI/LO
  logic             done_q, done_d;

  // Multiply: both operands widened to 2*WIDTH, so the truncated product is
  // exact for signed (sign-extended) and unsigned (zero-extended) inputs.
  logic [2*WIDTH-1:0] a_sext, b_sext, a_zext, b_zext, prod_s, prod_u;
  assign a_sext = {{WIDTH{src_a[WIDTH-1]}}, src_a};
  assign b_sext = {{WIDTH{src_b[WIDTH-1]}}, src_b};
  assign a_zext = {{WIDTH{1'b0}}, src_a};
  assign b_zext = {{WIDTH{1'b0}}, src_b};
  assign prod_s = a_sext * b_sext;
  assign prod_u = a_zext * b_zext;

  // Signed divide on magnitudes: quotient truncates toward zero, remainder
  // takes the dividend's sign. MIN/-1 falls out as quotient MIN, remainder 0.
  // A zero divisor is replaced by 1 to keep the datapath defined; the result
  // is never committed in that case.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, b_mag_safe, b_u_safe;
  logic [WIDTH-1:0] uq_s, ur_s, q_s, r_s, q_u, r_u;
  assign a_neg      = src_a[WIDTH-1];
  assign b_neg      = src_b[WIDTH-1];
  assign b_zero     = (src_b == '0);
  assign a_mag      = a_neg ? -src_a : src_a;
  assign b_mag      = b_neg ? -src_b : src_b;
  assign b_mag_safe = b_zero ? WIDTH'(1) : b_mag;
  assign b_u_safe   = b_zero ? WIDTH'(1) : src_b;
  assign uq_s       = a_mag / b_mag_safe;
  assign ur_s       = a_mag % b_mag_safe;
  assign q_s        = (a_neg ^ b_neg) ? -uq_s : uq_s;
  assign r_s        = a_neg ? -ur_s : ur_s;
  assign q_u        = src_a / b_u_safe;
  assign r_u        = src_a % b_u_safe;

`ifdef MDU_MADD_EN
  // Accumulate uses HI/LO as committed at the start edge.
  logic [2*WIDTH-1:0] hilo, madd_res, msub_res;
  assign hilo     = {hi_q, lo_q};
  assign madd_res = hilo + prod_s;
  assign msub_res = hilo - prod_s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT: begin
              state_d                = RUN;
              cnt_d                  = MUL_LOAD;
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d              = 1'b1;
            end
            OP_MULTU: begin
              state_d                = RUN;
              cnt_d                  = MUL_LOAD;
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d              = 1'b1;
            end
            OP_DIV: begin
              state_d   = RUN;
              cnt_d     = DIV_LOAD;
              pend_hi_d = r_s;
              pend_lo_d = q_s;
              pend_wr_d = !b_zero;
            end
            OP_DIVU: begin
              state_d   = RUN;
              cnt_d     = DIV_LOAD;
              pend_hi_d = r_u;
              pend_lo_d = q_u;
              pend_wr_d = !b_zero;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              state_d                = RUN;
              cnt_d                  = MUL_LOAD;
              {pend_hi_d, pend_lo_d} = madd_res;
              pend_wr_d              = 1'b1;
            end
            OP_MSUB: begin
              state_d                = RUN;
              cnt_d                  = MUL_LOAD;
              {pend_hi_d, pend_lo_d} = msub_res;
              pend_wr_d              = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        // Starts are ignored here; the hazard unit stalls issue while busy.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_e_mdu_iter.sv
// tb/tb_e_mdu_iter.sv - scoreboard bench for e_mdu_iter
module tb_e_mdu_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  e_mdu_iter #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected commit.
  always @(negedge clk) begin
    logic [63:0] e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("commit_hi", hi_out, e[63:32]);
        check("commit_lo", lo_out, e[31:0]);
      end
    end
  end

  // Called and returns aligned to a negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mdu_op = op;
    src_a  = a;
    src_b  = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = 4'd0;
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int n);
    int cnt;
    exp_q.push_back({eh, el});
    issue(op, a, b);
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    check(name, cnt, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = 4'd0;
    src_a  = '0;
    src_b  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // mthi/mtlo preload, then reset mid-multiply
    issue(4'd5, 32'h11, 32'd0);
    check("mthi_pre_hi", hi_out, 32'h11);
    issue(4'd6, 32'h22, 32'd0);
    check("mtlo_pre_lo", lo_out, 32'h22);
    issue(4'd1, 32'd3, 32'd4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_hi", hi_out, 32'd0);
    check("midrst_lo", lo_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_hi_late", hi_out, 32'd0);
    check("midrst_lo_late", lo_out, 32'd0);

    // multiply, then back-to-back multu issued in the done cycle
    run_op("mult_busy", 4'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    run_op("multu_busy", 4'd2, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 5);

    // divides
    run_op("div_neg_busy", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op("divu_busy", 4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    run_op("div_ovf_busy", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);

    // mthi/mtlo commit the same edge, then divide by zero keeps them
    issue(4'd5, 32'h1234, 32'd0);
    check("mthi_hi", hi_out, 32'h1234);
    check("mthi_lo_untouched", lo_out, 32'h80000000);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    issue(4'd6, 32'h5678, 32'd0);
    check("mtlo_lo", lo_out, 32'h5678);
    check("mtlo_hi_untouched", hi_out, 32'h1234);
    run_op("div0_busy", 4'd3, 32'd5, 32'd0, 32'h1234, 32'h5678, 10);

    // starts during busy are ignored
    exp_q.push_back({32'd0, 32'd42});
    issue(4'd1, 32'd6, 32'd7);
    issue(4'd6, 32'hAAAA, 32'd0);
    check("ign_mtlo_lo", lo_out, 32'h5678);
    issue(4'd1, 32'd100, 32'd100);
    cnt = 2;
    while (busy === 1'b1 && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    check("ign_busy", cnt, 32'd5);
    issue(4'd5, 32'h77, 32'd0);
    check("b2b_mthi_hi", hi_out, 32'h77);
    check("b2b_lo", lo_out, 32'd42);

    // op 0 and an unused code do nothing
    issue(4'd0, 32'h9999, 32'd1);
    check("op0_busy", {31'b0, busy}, 32'd0);
    issue(4'd9, 32'h9999, 32'd1);
    check("op9_busy", {31'b0, busy}, 32'd0);
    check("op9_hi", hi_out, 32'h77);
    check("op9_lo", lo_out, 32'd42);

    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
    run_op("madd_busy", 4'd7, 32'd1, 32'd1, 32'd1, 32'd0, 5);
    run_op("msub_busy", 4'd8, 32'd2, 32'd3, 32'd0, 32'hFFFFFFFA, 5);
`else
    issue(4'd7, 32'd1, 32'd1);
    check("op7_busy", {31'b0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("op7_hi", hi_out, 32'd0);
    check("op7_lo", lo_out, 32'hFFFFFFFF);
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
